// File: rtl/load_data_unit_if.sv
// Load-unit bus bundle: MEM-stage request, data-memory read port and writeback response.
// The adel flag exists only when LOAD_ALIGN_CHK_EN is defined.
interface load_data_unit_if;
   localparam int unsigned XLEN = 32;
   localparam int unsigned OP_W = 3;

   logic            ld_valid;
   logic            ld_ready;
   logic [OP_W-1:0] ld_op;
   logic [XLEN-1:0] ld_addr;
   logic            mem_req;
   logic [XLEN-1:0] mem_addr;
   logic            mem_ack;
   logic [XLEN-1:0] mem_rdata;
   logic            wb_valid;
   logic            wb_ready;
   logic [XLEN-1:0] wb_data;
   logic            bus_err;
`ifdef LOAD_ALIGN_CHK_EN
   logic            adel;
`endif

   // Pipeline/memory side: issues loads, answers reads, consumes results.
   modport master (
      output ld_valid, ld_op, ld_addr, mem_ack, mem_rdata, wb_ready,
`ifdef LOAD_ALIGN_CHK_EN
      input  ld_ready, mem_req, mem_addr, wb_valid, wb_data, bus_err, adel
`else
      input  ld_ready, mem_req, mem_addr, wb_valid, wb_data, bus_err
`endif
   );

   // Load unit side.
   modport slave (
      input  ld_valid, ld_op, ld_addr, mem_ack, mem_rdata, wb_ready,
`ifdef LOAD_ALIGN_CHK_EN
      output ld_ready, mem_req, mem_addr, wb_valid, wb_data, bus_err, adel
`else
      output ld_ready, mem_req, mem_addr, wb_valid, wb_data, bus_err
`endif
   );
endinterface

// File: rtl/load_data_unit.sv
// Load data unit: one word-aligned memory read per load, byte/half extraction and extension,
// timeout abort. Define LOAD_ALIGN_CHK_EN to reject misaligned LW/LH/LHU with adel.
module load_data_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   load_data_unit_if.slave  bus
);
   localparam int unsigned XLEN    = 32;
   localparam int unsigned TIMER_W = 8;

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LHU = 3'd2;
   localparam logic [2:0] OP_LB  = 3'd3;
   localparam logic [2:0] OP_LBU = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t             state;
   logic [2:0]         op_q;
   logic [1:0]         off_q;
   logic [TIMER_W-1:0] timer;
   logic               mem_req_q;
   logic [XLEN-1:0]    mem_addr_q;
   logic               wb_valid_q;
   logic [XLEN-1:0]    wb_data_q;
   logic               bus_err_q;

   logic [2:0]         op_norm_c;
   logic [7:0]         byte_c;
   logic [15:0]        half_c;
   logic [XLEN-1:0]    ext_data_c;

   // Reserved opcodes behave as LW from the moment they are accepted.
   assign op_norm_c = (bus.ld_op > OP_LBU) ? OP_LW : bus.ld_op;

   // Lane selection and extension of the returning word, little-endian.
   always_comb begin
      byte_c     = bus.mem_rdata[7:0];
      half_c     = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      ext_data_c = bus.mem_rdata;
      case (off_q)
         2'd1:    byte_c = bus.mem_rdata[15:8];
         2'd2:    byte_c = bus.mem_rdata[23:16];
         2'd3:    byte_c = bus.mem_rdata[31:24];
         default: byte_c = bus.mem_rdata[7:0];
      endcase
      case (op_q)
         OP_LH:   ext_data_c = {{16{half_c[15]}}, half_c};
         OP_LHU:  ext_data_c = {16'h0000, half_c};
         OP_LB:   ext_data_c = {{24{byte_c[7]}}, byte_c};
         OP_LBU:  ext_data_c = {24'h000000, byte_c};
         default: ext_data_c = bus.mem_rdata;
      endcase
   end

`ifdef LOAD_ALIGN_CHK_EN
   logic adel_q;
   logic misaligned_c;

   assign misaligned_c = ((op_norm_c == OP_LH || op_norm_c == OP_LHU) && bus.ld_addr[0]) ||
                         ((op_norm_c == OP_LW) && (bus.ld_addr[1:0] != 2'b00));
   assign bus.adel     = adel_q;
`endif

   // Request/response sequencer; every output except ld_ready comes from a flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         op_q       <= OP_LW;
         off_q      <= 2'b00;
         timer      <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         bus_err_q  <= 1'b0;
`ifdef LOAD_ALIGN_CHK_EN
         adel_q     <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.ld_valid) begin
                  op_q  <= op_norm_c;
                  off_q <= bus.ld_addr[1:0];
                  timer <= '0;
`ifdef LOAD_ALIGN_CHK_EN
                  if (misaligned_c) begin
                     wb_valid_q <= 1'b1;
                     wb_data_q  <= '0;
                     adel_q     <= 1'b1;
                     state      <= S_RESP;
                  end else begin
                     mem_addr_q <= {bus.ld_addr[XLEN-1:2], 2'b00};
                     mem_req_q  <= 1'b1;
                     state      <= S_WAIT;
                  end
`else
                  mem_addr_q <= {bus.ld_addr[XLEN-1:2], 2'b00};
                  mem_req_q  <= 1'b1;
                  state      <= S_WAIT;
`endif
               end
            end
            S_WAIT: begin
               // An ack arriving on the final timer cycle still delivers data.
               if (bus.mem_ack) begin
                  mem_req_q  <= 1'b0;
                  wb_data_q  <= ext_data_c;
                  wb_valid_q <= 1'b1;
                  state      <= S_RESP;
               end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                  mem_req_q  <= 1'b0;
                  wb_data_q  <= '0;
                  bus_err_q  <= 1'b1;
                  wb_valid_q <= 1'b1;
                  state      <= S_RESP;
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end
            S_RESP: begin
               if (bus.wb_ready) begin
                  wb_valid_q <= 1'b0;
                  bus_err_q  <= 1'b0;
`ifdef LOAD_ALIGN_CHK_EN
                  adel_q     <= 1'b0;
`endif
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.ld_ready = (state == S_IDLE);
   assign bus.mem_req  = mem_req_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_data  = wb_data_q;
   assign bus.bus_err  = bus_err_q;
endmodule
